mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit and its sequencing FSM for the RV32IM core. It sits beside the single-cycle ALU in the execute stage and takes over any operation whose decoded `alu_op` is 17–23 (mul, mulh, mulhu, div, divu, rem, remu). It holds the execute stage through a valid/ready handshake until the result is consumed. One operation is in flight at a time; shift-add multiply and restoring divide each take 32 iteration cycles.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` input 1: the single clock.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: execute stage offers an operation.
- `in_ready` output 1: unit can accept an operation.
- `alu_op` input 5: decoded op code; 17 mul, 18 mulh, 19 mulhu, 20 div, 21 divu, 22 rem, 23 remu.
- `src1` input 32: rs1 value (multiplicand / dividend).
- `src2` input 32: rs2 value (multiplier / divisor).
- `flush` input 1: abort any operation in flight.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: writeback consumes the result.
- `result` output 32: operation result.
- `busy` output 1: high whenever the state is not IDLE; used by the hazard logic.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - CALC: iterating; a 6-bit counter counts 0..31.
  - DONE: `out_valid`=1.
- Accept: the transaction fires on `in_valid && in_ready && alu_op∈[17,23]`. Any other `alu_op` is ignored and the state stays IDLE.
- On accept, latch the op, the operand signs and the operand magnitudes.
  - Signed ops take the absolute value: mul/mulh/div/rem signed, mulhu/divu/remu unsigned.
  - mul also uses magnitudes; its low word is sign-independent, but the same path is reused.
- Special cases on accept go straight to DONE with no CALC:
  - Divisor 0: div/divu give 0xFFFFFFFF; rem/remu give `src1`.
  - Signed overflow, `src1`=0x80000000 and `src2`=0xFFFFFFFF on div/rem: div gives 0x80000000, rem gives 0.
- Multiply: 64-bit accumulator, one shift-add per cycle.
  - mul returns the low 32 bits.
  - mulh/mulhu return the high 32 bits.
  - The sign fixup negates the full 64-bit product when sign1^sign2.
- Divide: restoring, one 33-bit trial subtract per cycle, yielding quotient and remainder.
  - Quotient is negated when sign1^sign2 (signed ops).
  - Remainder takes the dividend's sign.
- Transitions:
  - After CALC count 31, the fixed-up value is registered into `result` → DONE.
  - In DONE, `out_valid && out_ready` → IDLE.
- `flush` is highest priority after `rst`. In any state it forces IDLE next cycle, drops any pending result, and blocks a same-cycle accept.
- `rst`, including mid-CALC, gives: state IDLE, counter 0, `out_valid`=0, `result`=0, `busy`=0. `in_ready` is forced 0 while `rst` is high.

## Timing
- Accept edge at cycle N. CALC occupies N+1..N+32. `out_valid` rises at N+33.
- Special cases: `out_valid` rises at N+1.
- While `out_valid && !out_ready`, `result` and `out_valid` are held stable and `in_ready`=0.
- After the output handshake at cycle M, `in_ready`=1 at M+1. There is no back-to-back accept in DONE.
- `in_ready`, `busy` and `out_valid` are functions of state only. There is no combinational path from `in_valid` or `out_ready`.
- A `flush` in cycle F gives `in_ready`=1 at F+1.

## Structure
- Shared package `npc_pkg` holds the ALU op code constants (`ALU_MUL`=17 … `ALU_REMU`=23), used by decode, ALU and mdu, plus the mdu state enum.
- One natural sub-module, `mdu_core`: the iterative shift/add-subtract datapath with a `step` input and a `load` input. The top level `mdu` keeps the FSM, counter, special-case detect and sign fixup.

## Test plan
- Multiply: mul 7 × 0xFFFFFFFD → 0xFFFFFFEB, `out_valid` exactly 33 cycles after accept.
- High multiplies:
  - mulh 0x80000000 × 0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - mulh 0xFFFFFFFF × 1 → 0xFFFFFFFF.
- Divide and remainder:
  - div 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - rem −7, 2 → 0xFFFFFFFF.
  - divu 7/2 → 3.
  - remu 7/2 → 1.
- Special cases, result 1 cycle after accept:
  - divu 5/0 → 0xFFFFFFFF.
  - rem 5/0 → 5.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - rem of the same operands → 0.
- Backpressure: hold `out_ready`=0 for 5 cycles → `result` and `out_valid` stable and `in_ready`=0; release → handshake, then `in_ready`=1 on the next cycle.
- Abort and reject:
  - `flush` at N+10 → no `out_valid`; a new op is accepted at N+11 and gives the correct result.
  - `rst` at N+20 → all outputs at reset values next cycle.
  - `alu_op`=1 with `in_valid` → never accepted, `busy` stays 0.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared decode constants for the RV32IM execute stage and the mdu FSM state type.
package npc_pkg;

  localparam logic [4:0] ALU_MUL   = 5'd17;
  localparam logic [4:0] ALU_MULH  = 5'd18;
  localparam logic [4:0] ALU_MULHU = 5'd19;
  localparam logic [4:0] ALU_DIV   = 5'd20;
  localparam logic [4:0] ALU_DIVU  = 5'd21;
  localparam logic [4:0] ALU_REM   = 5'd22;
  localparam logic [4:0] ALU_REMU  = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative datapath shared by shift-add multiply and restoring divide.
// hi/lo form the 64-bit product, or remainder/quotient when dividing.
module mdu_core
  import npc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_nxt,
  output logic [31:0] lo_nxt
);

  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] b_r;
  logic        div_r;
  logic [32:0] sum_s;
  logic [32:0] shifted_s;
  logic [32:0] diff_s;

  // one iteration of either algorithm, chosen by the latched op kind
  always_comb begin
    sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : 33'd0);
    shifted_s = {hi_r, lo_r[31]};
    diff_s    = shifted_s - {1'b0, b_r};
    if (div_r) begin
      if (!diff_s[32]) begin
        hi_nxt = diff_s[31:0];
        lo_nxt = {lo_r[30:0], 1'b1};
      end else begin
        hi_nxt = shifted_s[31:0];
        lo_nxt = {lo_r[30:0], 1'b0};
      end
    end else begin
      hi_nxt = sum_s[32:1];
      lo_nxt = {sum_s[0], lo_r[31:1]};
    end
  end

  // working registers: load seeds them, step advances one iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r  <= 32'd0;
      lo_r  <= 32'd0;
      b_r   <= 32'd0;
      div_r <= 1'b0;
    end else if (load) begin
      hi_r  <= 32'd0;
      lo_r  <= a;
      b_r   <= b;
      div_r <= is_div;
    end else if (step) begin
      hi_r  <= hi_nxt;
      lo_r  <= lo_nxt;
    end else begin
      hi_r  <= hi_r;
      lo_r  <= lo_r;
    end
  end

endmodule

// File: rtl/mdu.sv
// RV32IM multiply/divide unit: handshake FSM, iteration counter,
// divide special cases and sign fixup around the iterative mdu_core.
module mdu
  import npc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  mdu_state_e  state_r;
  mdu_state_e  state_nxt_s;
  logic [5:0]  cnt_r;
  logic [4:0]  op_r;
  logic        neg_r;
  logic        sign1_r;
  logic [31:0] result_r;

  logic        accept_s;
  logic        signed_op_s;
  logic        sign1_s;
  logic        sign2_s;
  logic [31:0] mag1_s;
  logic [31:0] mag2_s;
  logic        div_zero_s;
  logic        ovf_s;
  logic        special_s;
  logic [31:0] special_val_s;
  logic        last_s;
  logic [31:0] hi_nxt_s;
  logic [31:0] lo_nxt_s;
  logic [63:0] prod_fix_s;
  logic [31:0] fix_s;

  assign in_ready  = (state_r == ST_IDLE) && !rst;
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r != ST_IDLE);
  assign result    = result_r;

  assign accept_s    = in_valid && in_ready && is_mdu_op(alu_op) && !flush;
  assign signed_op_s = (alu_op == ALU_MUL) || (alu_op == ALU_MULH) ||
                       (alu_op == ALU_DIV) || (alu_op == ALU_REM);
  assign sign1_s     = signed_op_s && src1[31];
  assign sign2_s     = signed_op_s && src2[31];
  assign mag1_s      = sign1_s ? (32'd0 - src1) : src1;
  assign mag2_s      = sign2_s ? (32'd0 - src2) : src2;
  assign div_zero_s  = is_div_op(alu_op) && (src2 == 32'd0);
  assign ovf_s       = ((alu_op == ALU_DIV) || (alu_op == ALU_REM)) &&
                       (src1 == 32'h8000_0000) && (src2 == 32'hFFFF_FFFF);
  assign special_s   = div_zero_s || ovf_s;
  assign last_s      = (state_r == ST_CALC) && (cnt_r == 6'd31);

  // dividend/multiplier goes in lo, divisor/multiplicand in the adder operand
  mdu_core u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept_s),
    .step   (state_r == ST_CALC),
    .is_div (is_div_op(alu_op)),
    .a      (is_div_op(alu_op) ? mag1_s : mag2_s),
    .b      (is_div_op(alu_op) ? mag2_s : mag1_s),
    .hi_nxt (hi_nxt_s),
    .lo_nxt (lo_nxt_s)
  );

  // results that bypass iteration
  always_comb begin
    special_val_s = 32'hFFFF_FFFF;
    if (div_zero_s) begin
      if ((alu_op == ALU_REM) || (alu_op == ALU_REMU)) begin
        special_val_s = src1;
      end else begin
        special_val_s = 32'hFFFF_FFFF;
      end
    end else if (ovf_s) begin
      special_val_s = (alu_op == ALU_REM) ? 32'd0 : 32'h8000_0000;
    end else begin
      special_val_s = 32'hFFFF_FFFF;
    end
  end

  // sign fixup of the final iteration's value
  always_comb begin
    prod_fix_s = neg_r ? (64'd0 - {hi_nxt_s, lo_nxt_s}) : {hi_nxt_s, lo_nxt_s};
    case (op_r)
      ALU_MUL:            fix_s = prod_fix_s[31:0];
      ALU_MULH, ALU_MULHU: fix_s = prod_fix_s[63:32];
      ALU_DIV:            fix_s = neg_r ? (32'd0 - lo_nxt_s) : lo_nxt_s;
      ALU_REM:            fix_s = sign1_r ? (32'd0 - hi_nxt_s) : hi_nxt_s;
      ALU_REMU:           fix_s = hi_nxt_s;
      default:            fix_s = lo_nxt_s;
    endcase
  end

  // next-state logic; flush overrides every transition
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = special_s ? ST_DONE : ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: state_nxt_s = (cnt_r == 6'd31) ? ST_DONE : ST_CALC;
      ST_DONE: state_nxt_s = out_ready ? ST_IDLE : ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // state, counter, latched operation context and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 6'd0;
      op_r     <= 5'd0;
      neg_r    <= 1'b0;
      sign1_r  <= 1'b0;
      result_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= ((state_r == ST_CALC) && !flush) ? (cnt_r + 6'd1) : 6'd0;
      if (accept_s) begin
        op_r    <= alu_op;
        neg_r   <= sign1_s ^ sign2_s;
        sign1_r <= sign1_s;
      end
      if (accept_s && special_s) begin
        result_r <= special_val_s;
      end else if (last_s && !flush) begin
        result_r <= fix_s;
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases, random ops against an
// arithmetic reference model, backpressure, flush, reset and reject.
module tb_mdu;
  import npc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics using wide plain arithmetic
  function automatic logic [31:0] ref_mdu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ps;
    logic [63:0] pu;
    logic [63:0] q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = sa * sb;
    pu = {32'd0, a} * {32'd0, b};
    case (op)
      5'd17: return ps[31:0];
      5'd18: return ps[63:32];
      5'd19: return pu[63:32];
      5'd20: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        q = sa / sb;
        return q[31:0];
      end
      5'd21: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'd22: begin
        if (b == 32'd0) return a;
        q = sa % sb;
        return q[31:0];
      end
      5'd23: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd20 && b == 32'd0) return 1;
    if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one op with out_ready high; checks value, latency and return to idle
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    alu_op   = op;
    src1     = a;
    src2     = b;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check(tag, result, ref_mdu(op, a, b));
    check({tag, "_lat"}, n, ref_latency(op, a, b));
    tick();
    check({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic [4:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;
    rst = 1'b1; in_valid = 1'b0; alu_op = 5'd0; src1 = 32'd0; src2 = 32'd0;
    flush = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("rst_rdy", {31'd0, in_ready}, 32'd0);
    check("rst_outs", {30'd0, out_valid, busy}, 32'd0);
    check("rst_res", result, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_rdy", {31'd0, in_ready}, 32'd1);

    do_op("mul",    ALU_MUL,   32'd7,          32'hFFFF_FFFD);
    do_op("mulh",   ALU_MULH,  32'h8000_0000,  32'h8000_0000);
    do_op("mulhu",  ALU_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    do_op("mulh1",  ALU_MULH,  32'hFFFF_FFFF,  32'd1);
    do_op("div",    ALU_DIV,   32'hFFFF_FFF9,  32'd2);
    do_op("rem",    ALU_REM,   32'hFFFF_FFF9,  32'd2);
    do_op("divu",   ALU_DIVU,  32'd7,          32'd2);
    do_op("remu",   ALU_REMU,  32'd7,          32'd2);
    do_op("divu0",  ALU_DIVU,  32'd5,          32'd0);
    do_op("rem0",   ALU_REM,   32'd5,          32'd0);
    do_op("divovf", ALU_DIV,   32'h8000_0000,  32'hFFFF_FFFF);
    do_op("removf", ALU_REM,   32'h8000_0000,  32'hFFFF_FFFF);

    for (int i = 0; i < 24; i++) begin
      rop = 5'(17 + $urandom_range(6));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(200); rb = $urandom_range(1, 15); end
        3: rb = 32'(-$urandom_range(1, 9));
        default: ;
      endcase
      do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
    end

    // backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = ALU_MULHU; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    held = ref_mdu(ALU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    check("bp_lat", n, 33);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_res", result, held);
      check("bp_flags", {29'd0, out_valid, in_ready, busy}, 32'd5);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);

    // flush at N+10 with a competing request that must not be taken
    in_valid = 1'b1; alu_op = ALU_MUL; src1 = 32'd1000; src2 = 32'd3;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1; in_valid = 1'b1; alu_op = ALU_DIVU; src1 = 32'd99; src2 = 32'd4;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_state", {29'd0, out_valid, busy, in_ready}, 32'd1);
    do_op("post_flush", ALU_DIVU, 32'd100, 32'd7);

    // reset in the middle of CALC, after a nonzero result is held
    in_valid = 1'b1; alu_op = ALU_MUL; src1 = 32'd3; src2 = 32'd5;
    tick();
    in_valid = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_flags", {29'd0, out_valid, busy, in_ready}, 32'd0);
    check("mid_rst_res", result, 32'd0);
    rst = 1'b0;
    tick();
    check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);

    // non-mdu opcodes are never accepted
    in_valid = 1'b1; alu_op = 5'd1; src1 = 32'd9; src2 = 32'd9;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("reject", {30'd0, busy, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    do_op("after_reject", ALU_REMU, 32'd1001, 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
